// File: rtl/ft245_fifo_bridge_pkg.sv
// Shared types and constants for the FT245-style FIFO bridge.
package ft245_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RD,
    R_HOLD,
    R_GAP
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HOLD,
    T_GAP
  } tx_state_t;

  // Bit positions inside the sticky error vector
  localparam int unsigned ERR_WR  = 0;
  localparam int unsigned ERR_RD  = 1;
  localparam int unsigned ERR_OVF = 2;

endpackage

// File: rtl/ft245_fifo_bridge_sync_fifo.sv
// Single-clock FIFO for any depth >= 2; the head is visible combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ft245_fifo_bridge.sv
// FT245-style parallel FIFO port on the CPU side, valid/ready byte streams on the serial side.
module ft245_fifo_bridge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned T3          = 2,
  parameter int unsigned T5          = 1,
  parameter int unsigned T6          = 3,
  parameter int unsigned T11         = 1,
  parameter int unsigned T12         = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RX_DROP     = 0
) (
  input  logic             clk,
  input  logic             _MR,
  inout  wire  [WIDTH-1:0] D,
  input  logic             WR,
  input  logic             _RD,
  output logic             _TXE,
  output logic             _RXF,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [2:0]       err,
  input  logic             err_clr
);
  import ft245_pkg::*;

  localparam int unsigned RX_CW = $clog2(RX_DEPTH + 1);
  localparam int unsigned TX_CW = $clog2(TX_DEPTH + 1);

  logic [SYNC_STAGES-1:0]            wr_sync_q, rd_sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] d_sync_q;
  logic                              wr_dly_q, rd_dly_q;
  logic                              wr_fall, rd_fall, rd_rise;
  logic [WIDTH-1:0]                  d_last;

  rx_state_t        rx_state_q;
  tx_state_t        tx_state_q;
  logic [7:0]       rx_cnt_q, tx_cnt_q;   // phase timers; all timings assumed < 255
  logic             d_oe_q, rxf_q, txe_q;
  logic [2:0]       err_q, err_set;

  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [WIDTH-1:0] rx_head;
  logic [RX_CW-1:0] rx_count;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_CW-1:0] tx_count;

  // Synchronise the CPU strobes and data bus; one extra flop per strobe for edge detection
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      wr_sync_q <= '1;
      rd_sync_q <= '1;
      d_sync_q  <= '0;
      wr_dly_q  <= 1'b1;
      rd_dly_q  <= 1'b1;
    end else begin
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], WR};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], _RD};
      d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], D};
      wr_dly_q  <= wr_sync_q[SYNC_STAGES-1];
      rd_dly_q  <= rd_sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_fall = wr_dly_q && !wr_sync_q[SYNC_STAGES-1];
  assign rd_fall = rd_dly_q && !rd_sync_q[SYNC_STAGES-1];
  assign rd_rise = !rd_dly_q && rd_sync_q[SYNC_STAGES-1];
  assign d_last  = d_sync_q[SYNC_STAGES-1];

  // RX FIFO push/pop; in drop mode a full FIFO silently discards unless a pop frees a slot
  assign rx_pop   = (rx_state_q == R_HOLD) && (rx_cnt_q == 8'(T5 - 1)) && !rx_empty;
  assign rx_push  = rx_valid && (!rx_full || ((RX_DROP != 0) && rx_pop));
  assign rx_ready = (RX_DROP != 0) ? 1'b1 : !rx_full;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (_MR),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign tx_push  = (tx_state_q == T_IDLE) && wr_fall && !txe_q && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (_MR),
    .push      (tx_push),
    .push_data (d_last),
    .pop       (tx_pop),
    .head      (tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // RX read cycle: drive D T3 cycles after the fall, release on rise, then hold and gap
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      d_oe_q     <= 1'b0;
      rxf_q      <= 1'b1;
    end else begin
      rxf_q <= !((rx_count != '0) && (rx_state_q == R_IDLE));
      unique case (rx_state_q)
        R_IDLE: if (rd_fall) begin
          rx_state_q <= R_RD;
          rx_cnt_q   <= 8'd1;   // the detection cycle already counts
          d_oe_q     <= (T3 <= 1);
        end
        R_RD: if (rd_rise) begin
          rx_state_q <= R_HOLD;
          rx_cnt_q   <= '0;
          d_oe_q     <= 1'b0;
        end else begin
          if (rx_cnt_q == 8'(T3 - 1)) d_oe_q <= 1'b1;
          if (rx_cnt_q != '1)         rx_cnt_q <= rx_cnt_q + 8'd1;
        end
        R_HOLD: if (rx_cnt_q == 8'(T5 - 1)) begin
          rx_state_q <= R_GAP;
          rx_cnt_q   <= '0;
        end else begin
          rx_cnt_q <= rx_cnt_q + 8'd1;
        end
        R_GAP: if (rx_cnt_q == 8'(T6 - 1)) begin
          rx_state_q <= R_IDLE;
          rx_cnt_q   <= '0;
        end else begin
          rx_cnt_q <= rx_cnt_q + 8'd1;
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // TX write cycle: the push happens on the detected WR fall, then hold and gap
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      txe_q      <= 1'b1;
    end else begin
      txe_q <= !((tx_count < TX_CW'(TX_DEPTH)) && (tx_state_q == T_IDLE));
      unique case (tx_state_q)
        T_IDLE: if (tx_push) begin
          tx_state_q <= T_HOLD;
          tx_cnt_q   <= '0;
        end
        T_HOLD: if (tx_cnt_q == 8'(T11 - 1)) begin
          tx_state_q <= T_GAP;
          tx_cnt_q   <= '0;
        end else begin
          tx_cnt_q <= tx_cnt_q + 8'd1;
        end
        T_GAP: if (tx_cnt_q == 8'(T12 - 1)) begin
          tx_state_q <= T_IDLE;
          tx_cnt_q   <= '0;
        end else begin
          tx_cnt_q <= tx_cnt_q + 8'd1;
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  // New protocol errors detected this cycle
  always_comb begin
    err_set          = '0;
    err_set[ERR_WR]  = wr_fall && txe_q;
    err_set[ERR_RD]  = rd_fall && rxf_q;
    err_set[ERR_OVF] = (RX_DROP != 0) && rx_valid && rx_full && !rx_pop;
  end

  // Sticky error flags; a clear loses against a simultaneous new error
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) err_q <= '0;
    else      err_q <= (err_clr ? 3'b000 : err_q) | err_set;
  end

  assign D    = d_oe_q ? rx_head : 'z;
  assign _RXF = rxf_q;
  assign _TXE = txe_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed bench: default instance for reset/RX/TX/errors, a small drop-mode instance for
// overflow, and a depth-5 instance for pointer wrap under concurrent traffic.
module tb_ft245_fifo_bridge;

  logic clk = 1'b0;
  logic mr_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: defaults
  logic       wr0 = 1'b1, rd_n0 = 1'b1, d_oe0 = 1'b0, rx_valid0 = 1'b0;
  logic       tx_ready0 = 1'b0, err_clr0 = 1'b0;
  logic [7:0] d_drv0 = '0, rx_data0 = '0;
  tri1  [7:0] d0;
  logic       txe0, rxf0, rx_ready0, tx_valid0;
  logic [7:0] tx_data0;
  logic [2:0] err0;
  assign d0 = d_oe0 ? d_drv0 : 'z;

  // Instances 1 and 2: RX path only
  logic       wr_idle = 1'b1, ready_hi = 1'b1, clr_lo = 1'b0;
  logic       rd_n1 = 1'b1, rd_n2 = 1'b1, rx_valid1 = 1'b0, rx_valid2 = 1'b0;
  logic [7:0] rx_data1 = '0, rx_data2 = '0;
  tri1  [7:0] d1, d2;
  logic       txe1, rxf1, rx_ready1, tx_valid1, txe2, rxf2, rx_ready2, tx_valid2;
  logic [7:0] tx_data1, tx_data2;
  logic [2:0] err1, err2;

  ft245_fifo_bridge u_dut0 (
    .clk(clk), ._MR(mr_n), .D(d0), .WR(wr0), ._RD(rd_n0), ._TXE(txe0), ._RXF(rxf0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .err(err0), .err_clr(err_clr0)
  );

  ft245_fifo_bridge #(.RX_DEPTH(3), .RX_DROP(1)) u_dut1 (
    .clk(clk), ._MR(mr_n), .D(d1), .WR(wr_idle), ._RD(rd_n1), ._TXE(txe1), ._RXF(rxf1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .tx_data(tx_data1),
    .tx_valid(tx_valid1), .tx_ready(ready_hi), .err(err1), .err_clr(clr_lo)
  );

  ft245_fifo_bridge #(.RX_DEPTH(5)) u_dut2 (
    .clk(clk), ._MR(mr_n), .D(d2), .WR(wr_idle), ._RD(rd_n2), ._TXE(txe2), ._RXF(rxf2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(ready_hi), .err(err2), .err_clr(clr_lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] d_of(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic rxf_of(input int k);
    case (k)
      0:       return rxf0;
      1:       return rxf1;
      default: return rxf2;
    endcase
  endfunction

  function automatic logic ready_of(input int k);
    case (k)
      0:       return rx_ready0;
      1:       return rx_ready1;
      default: return rx_ready2;
    endcase
  endfunction

  task automatic set_rd(input int k, input logic v);
    case (k)
      0:       rd_n0 = v;
      1:       rd_n1 = v;
      default: rd_n2 = v;
    endcase
  endtask

  task automatic set_rx(input int k, input logic v, input logic [7:0] b);
    case (k)
      0:       begin rx_valid0 = v; rx_data0 = b; end
      1:       begin rx_valid1 = v; rx_data1 = b; end
      default: begin rx_valid2 = v; rx_data2 = b; end
    endcase
  endtask

  // Offer one byte on the serial side and hold it until accepted
  task automatic push_rx(input int k, input logic [7:0] b);
    int budget = 0;
    set_rx(k, 1'b1, b);
    while (!ready_of(k) && budget < 1000) begin
      tick();
      budget++;
    end
    if (!ready_of(k)) check_eq("rx_ready_wait", ready_of(k), 1);
    tick();
    set_rx(k, 1'b0, b);
  endtask

  // Six-cycle _RD pulse; bus is pulled up to FF whenever nobody drives it
  task automatic rd_pulse(input int k, input logic [7:0] exp, input logic chk_end,
                          input logic rxf_end);
    set_rd(k, 1'b0);
    repeat (3) tick();
    check_eq("d_hiz_before_t3", d_of(k), 8'hFF);
    tick();
    check_eq("d_read", d_of(k), exp);
    repeat (2) tick();
    set_rd(k, 1'b1);
    repeat (3) tick();
    check_eq("d_hiz_after_rise", d_of(k), 8'hFF);
    repeat (3) tick();
    check_eq("rxf_in_gap", rxf_of(k), 1);
    repeat (2) tick();
    if (chk_end) check_eq("rxf_after_read", rxf_of(k), rxf_end);
  endtask

  task automatic wait_rxf_low(input int k);
    int budget = 0;
    while (rxf_of(k) && budget < 500) begin
      tick();
      budget++;
    end
    if (rxf_of(k)) check_eq("rxf_wait", rxf_of(k), 0);
  endtask

  task automatic wait_txe_low();
    int budget = 0;
    while (txe0 && budget < 100) begin
      tick();
      budget++;
    end
    if (txe0) check_eq("txe_wait", txe0, 0);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    d_drv0 = b;
    d_oe0  = 1'b1;
    wr0    = 1'b0;
    repeat (3) tick();
    wr0   = 1'b1;
    d_oe0 = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    check_eq("rst_rxf", rxf0, 1);
    check_eq("rst_txe", txe0, 1);
    check_eq("rst_err", err0, 0);
    check_eq("rst_tx_valid", tx_valid0, 0);
    check_eq("rst_rx_ready", rx_ready0, 1);
    check_eq("rst_d_hiz", d0, 8'hFF);
    mr_n = 1'b1;
    repeat (2) tick();

    // Reset in the middle of a read with D driven
    push_rx(0, 8'h33);
    rd_n0 = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_d", d0, 8'h33);
    mr_n = 1'b0;
    tick();
    check_eq("midrst_d_hiz", d0, 8'hFF);
    check_eq("midrst_rxf", rxf0, 1);
    check_eq("midrst_txe", txe0, 1);
    check_eq("midrst_err", err0, 0);
    rd_n0 = 1'b1;
    repeat (2) tick();
    mr_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_rxf", rxf0, 1);

    // RX: two bytes read back in order
    push_rx(0, 8'h41);
    push_rx(0, 8'h42);
    repeat (2) tick();
    check_eq("rx_rxf_ready", rxf0, 0);
    rd_pulse(0, 8'h41, 1'b1, 1'b0);
    rd_pulse(0, 8'h42, 1'b1, 1'b1);
    check_eq("rx_err_none", err0, 0);

    // TX: single write timing, then fill to depth
    wait_txe_low();
    d_drv0 = 8'h5A;
    d_oe0  = 1'b1;
    wr0    = 1'b0;
    repeat (3) tick();
    check_eq("tx_valid", tx_valid0, 1);
    check_eq("tx_data", tx_data0, 8'h5A);
    tick();
    wr0   = 1'b1;
    d_oe0 = 1'b0;
    check_eq("txe_hold", txe0, 1);
    repeat (3) tick();
    check_eq("txe_gap_end", txe0, 1);
    tick();
    check_eq("txe_back_low", txe0, 0);
    for (int i = 1; i < 16; i++) begin
      wr_byte(8'(8'h60 + i));
      if (i < 15) wait_txe_low();
    end
    repeat (10) tick();
    check_eq("txe_full", txe0, 1);
    check_eq("tx_head_full", tx_data0, 8'h5A);
    check_eq("tx_err_none", err0, 0);
    tx_ready0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("tx_drain", tx_data0, (i == 0) ? 8'h5A : 8'(8'h60 + i));
      tick();
    end
    check_eq("tx_drained", tx_valid0, 0);
    tx_ready0 = 1'b0;

    // Errors: WR during gap, read of empty FIFO, clear racing a new error
    wait_txe_low();
    wr_byte(8'h11);
    wr_byte(8'h22);
    check_eq("err_wr_gap", err0, 3'b001);
    rd_n0 = 1'b0;
    repeat (6) tick();
    rd_n0 = 1'b1;
    repeat (10) tick();
    check_eq("err_rd_empty", err0, 3'b011);
    wait_txe_low();
    wr_byte(8'h33);
    d_drv0 = 8'h44;
    d_oe0  = 1'b1;
    wr0    = 1'b0;
    repeat (2) tick();
    err_clr0 = 1'b1;
    tick();
    err_clr0 = 1'b0;
    check_eq("err_clr_vs_new", err0, 3'b001);
    wr0   = 1'b1;
    d_oe0 = 1'b0;
    repeat (2) tick();
    tx_ready0 = 1'b1;
    check_eq("err_tx_first", tx_data0, 8'h11);
    tick();
    check_eq("err_tx_second", tx_data0, 8'h33);
    tick();
    check_eq("err_no_push", tx_valid0, 0);
    tx_ready0 = 1'b0;

    // Overflow in drop mode, depth 3
    push_rx(1, 8'hC1);
    push_rx(1, 8'hC2);
    push_rx(1, 8'hC3);
    push_rx(1, 8'hC4);
    tick();
    check_eq("ovf_err", err1, 3'b100);
    check_eq("ovf_ready_tied", rx_ready1, 1);
    check_eq("ovf_rxf", rxf1, 0);
    rd_pulse(1, 8'hC1, 1'b1, 1'b0);
    rd_pulse(1, 8'hC2, 1'b1, 1'b0);
    rd_pulse(1, 8'hC3, 1'b1, 1'b1);
    check_eq("ovf_err_sticky", err1, 3'b100);

    // Wrap with depth 5: prefill to full, then stream while reading
    for (int i = 0; i < 5; i++) push_rx(2, 8'(8'h80 + i));
    tick();
    check_eq("wrap_full_ready", rx_ready2, 0);
    fork
      begin
        for (int i = 5; i < 20; i++) push_rx(2, 8'(8'h80 + i));
      end
      begin
        for (int j = 0; j < 20; j++) begin
          wait_rxf_low(2);
          rd_pulse(2, 8'(8'h80 + j), 1'b0, 1'b0);
        end
      end
    join
    repeat (2) tick();
    check_eq("wrap_err_none", err2, 0);
    check_eq("wrap_empty", rxf2, 1);
    check_eq("wrap_ready", rx_ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
